// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline stall/flush controller with stall watchdog.
// Define STALL_PERF_CNT_EN to build the stall_cycles/flush_count performance counters.
module stall_ctrl #(
    parameter logic [15:0] STALL_TIMEOUT = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        flush_req,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        stall_timeout,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
    state_t      state_q, state_d;
    logic [15:0] run_cnt_q, run_cnt_d;
    logic        any_req, active;
    // The watchdog counts consecutive stalling cycles, including the RUN cycle that raised the stall.
    always_comb begin
        any_req       = stallreq_id || stallreq_ex || stallreq_mem;
        active        = rst && state_q != FLUSH && any_req && !flush_req;
        stall_timeout = active && run_cnt_q == STALL_TIMEOUT - 16'd1;
        flush         = state_q == FLUSH;
        stall         = !rst || state_q == FLUSH ? 6'b000000 :
                        flush_req    ? 6'b111111 :
                        stallreq_mem ? 6'b011111 :
                        stallreq_ex  ? 6'b001111 :
                        stallreq_id  ? 6'b000111 : 6'b000000;
        state_d       = flush_req || stall_timeout ? FLUSH :
                        state_q == FLUSH           ? RUN   :
                        any_req                    ? STALL : RUN;
        run_cnt_d     = active && !stall_timeout ? run_cnt_q + 16'd1 : 16'd0;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= RUN;
            run_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
        end
    end
`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q, flush_count_d;
    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, |stall};
        flush_count_d  = flush_count_q + {15'd0, flush};
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end
    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 16'd0;
`endif
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed and random checks of stall_ctrl against a cycle-level behavioural model.
module tb_stall_ctrl;
    localparam int T = 4;
`ifdef STALL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst, stallreq_id, stallreq_ex, stallreq_mem, flush_req;
    logic [5:0]  stall;
    logic        flush, stall_timeout;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
    int          n_assert = 0, n_fail = 0;
    bit          m_pend = 1'b0;
    int          m_run = 0;
    logic [31:0] m_sc = 32'd0;
    logic [15:0] m_fc = 16'd0;

    stall_ctrl #(.STALL_TIMEOUT(16'(T))) dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .stallreq_mem(stallreq_mem), .flush_req(flush_req), .stall(stall), .flush(flush),
        .stall_timeout(stall_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model across the edge.
    task automatic step(input logic r, input logic id, input logic ex, input logic mem, input logic fr);
        logic [5:0] es;
        logic       ef, et, anyr;
        rst = r; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem; flush_req = fr;
        @(negedge clk);
        anyr = id || ex || mem;
        es = (!r || m_pend) ? 6'h00 : fr ? 6'h3f : mem ? 6'h1f : ex ? 6'h0f : id ? 6'h07 : 6'h00;
        ef = m_pend;
        et = r && !m_pend && !fr && anyr && m_run == T - 1;
        chk("stall", {26'd0, stall}, {26'd0, es});
        chk("flush", {31'd0, flush}, {31'd0, ef});
        chk("stall_timeout", {31'd0, stall_timeout}, {31'd0, et});
        chk("stall_cycles", stall_cycles, PERF ? m_sc : 32'd0);
        chk("flush_count", {16'd0, flush_count}, PERF ? {16'd0, m_fc} : 32'd0);
        @(posedge clk);
        if (!r) begin
            m_pend = 1'b0; m_run = 0; m_sc = 32'd0; m_fc = 16'd0;
        end else begin
            m_sc = m_sc + ((es != 6'h00) ? 32'd1 : 32'd0);
            m_fc = m_fc + (ef ? 16'd1 : 16'd0);
            m_run = (!m_pend && !fr && anyr && !et) ? m_run + 1 : 0;
            m_pend = fr || et;
        end
        #1;
    endtask

    initial begin
        rst = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0; flush_req = 1'b0;
        @(posedge clk); #1;
        step(0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0);
        // ex stall for three cycles
        repeat (3) step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("ex3_stall_cycles", stall_cycles, PERF ? 32'd3 : 32'd0);
        // id+mem, then drop mem
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // flush during ex stall
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 1);
        step(1, 0, 1, 0, 0);
        chk("flush_after_req", {31'd0, flush}, 32'd0);
        step(1, 0, 0, 0, 0);
        // watchdog: mem held
        repeat (12) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        // flush_req held across FLUSH re-enters FLUSH
        repeat (3) step(1, 1, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        // reset after two stall cycles
        repeat (2) step(1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        // reset during FLUSH
        step(1, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(39) != 0, $urandom_range(2) == 0, $urandom_range(3) == 0,
                 $urandom_range(2) == 0, $urandom_range(11) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameter STALL_TIMEOUT, default 16'd1024, the maximum number of consecutive stall cycles before a forced flush; legal range 2..65535.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous reset, active-low (0 = reset).
REQ-004 stallreq_id  in  1  stall request from the ID stage.
REQ-005 stallreq_ex  in  1  stall request from the EX stage (multi-cycle madd/msub/div).
REQ-006 stallreq_mem  in  1  stall request from the MEM stage (bus wait).
REQ-007 flush_req  in  1  exception flush request.
REQ-008 stall  out  6  per-stage hold; bit0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB; 1 = Stop.
REQ-009 flush  out  1  pipeline flush pulse.
REQ-010 stall_timeout  out  1  one-cycle pulse when the watchdog fires.
REQ-011 stall_cycles  out  32  performance count of cycles with stall != 0.
REQ-012 flush_count  out  16  performance count of flush pulses.

Function
REQ-013 The FSM states SHALL be RUN, STALL and FLUSH.
REQ-014 The stall output SHALL be combinational from the current requests, with zero latency.
- Priority: flush_req > stallreq_mem > stallreq_ex > stallreq_id.
REQ-015 Stall encodings in RUN or STALL SHALL be:
- flush_req → 6'b111111
- mem → 6'b011111
- ex → 6'b001111
- id → 6'b000111
- none → 6'b000000
REQ-016 State transitions:
- RUN to STALL when any stallreq is high and flush_req is low.
- STALL to RUN when all requests are low.
- Any state to FLUSH on the edge after flush_req = 1 or after a watchdog expiry.
REQ-017 In FLUSH, flush SHALL be 1 and stall SHALL be 6'b000000 for exactly one cycle, ignoring stall requests; the next state is RUN.
- A flush_req that is still high in FLUSH re-enters FLUSH.
REQ-018 The 16-bit run counter SHALL increment each cycle in STALL while any request persists, and clear on entry to RUN or FLUSH.
REQ-019 When the run counter equals STALL_TIMEOUT-1 and a request is still high, stall_timeout SHALL pulse for 1 cycle and the next state SHALL be FLUSH.
REQ-020 A change of stall source within STALL (e.g. id to mem) SHALL NOT clear the run counter.
REQ-021 flush SHALL be 0 in the cycle flush_req first rises; the flush pulse has 1-cycle latency.
REQ-022 stall_cycles SHALL increment when stall != 0 and wrap from 32'hFFFFFFFF to 0.
REQ-023 flush_count SHALL increment per flush pulse and wrap at 16'hFFFF.

Reset
REQ-024 While rst = 0 at a clock edge, the block SHALL set:
- state = RUN
- run counter = 0
- flush = 0
- stall_timeout = 0
- stall_cycles = 0
- flush_count = 0
REQ-025 During reset, stall SHALL be 6'b000000 regardless of requests.
REQ-026 Reset asserted mid-stall or mid-flush SHALL abort the operation with no flush pulse on the following cycle.

Configuration
REQ-027 Macro STALL_PERF_CNT_EN defined: stall_cycles and flush_count SHALL behave per REQ-022 and REQ-023.
REQ-028 Macro STALL_PERF_CNT_EN undefined: stall_cycles and flush_count SHALL be constant 0 with no counter registers; all other behaviour SHALL be identical.

Verification
REQ-029 Reset, then stallreq_ex = 1 for 3 cycles → stall = 6'b001111 in those 3 cycles, then 6'b000000; stall_cycles = 3.
REQ-030 stallreq_id = 1 and stallreq_mem = 1 together → stall = 6'b011111; drop mem → 6'b000111 in the same cycle.
REQ-031 flush_req = 1 for 1 cycle during stallreq_ex → that cycle stall = 6'b111111; next cycle flush = 1, stall = 0; then RUN; flush_count = 1.
REQ-032 STALL_TIMEOUT = 4, stallreq_mem held high → stall_timeout pulses on the 4th stall cycle; next cycle flush = 1; the counter restarts afterwards.
REQ-033 rst = 0 during FLUSH or after 2 stall cycles → all outputs 0 on the next edge; no flush follows.
REQ-034 Build without STALL_PERF_CNT_EN and rerun REQ-029 → stall_cycles = 0 and flush_count = 0; stall and flush waveforms unchanged.
